// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shared 32-step shift-add / restoring shift-subtract datapath.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [5:0]      r_count;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_is_div;
    logic            w_sa;
    logic            w_sb;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;
    logic            w_neg;
    logic            w_last;
    logic            w_done;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_dv;
    logic [XLEN-1:0]   w_dv_s;
    logic [XLEN-1:0]   w_final;

    // Operand decode: signedness, magnitudes, special cases
    always_comb begin
        w_is_div = funct3[2];
        if (w_is_div) begin
            w_sa = ~funct3[0];
            w_sb = ~funct3[0];
        end else begin
            w_sa = (funct3[1:0] != 2'b11);
            w_sb = ~funct3[1];
        end
        w_a_neg   = w_sa & rs1[XLEN-1];
        w_b_neg   = w_sb & rs2[XLEN-1];
        w_a_mag   = w_a_neg ? -rs1 : rs1;
        w_b_mag   = w_b_neg ? -rs2 : rs2;
        w_div0    = w_is_div & (rs2 == '0);
        w_ovf     = w_is_div & ~funct3[0]
                  & (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                  & (rs2 == '1);
        w_neg     = (w_is_div & funct3[1]) ? w_a_neg
                                           : (w_a_neg ^ w_b_neg);
        if (w_div0)
            w_special = funct3[1] ? rs1 : '1;
        else
            w_special = funct3[1] ? '0 : rs1;
        w_accept  = (r_state == S_IDLE) & start & ~flush;
    end

    // One datapath step plus sign-corrected final value
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift   = {r_hi, r_lo[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, r_b});
        w_diff    = w_shift[XLEN-1:0] - r_b;
        if (r_op[2]) begin
            w_hi_n = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_n = w_mul_sum[XLEN:1];
            w_lo_n = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_hi_n, w_lo_n};
        w_prod_s = r_neg ? -w_prod : w_prod;
        w_dv     = r_op[1] ? w_hi_n : w_lo_n;
        w_dv_s   = r_neg ? -w_dv : w_dv;
        if (r_op[2])
            w_final = w_dv_s;
        else if (r_op[1:0] == 2'b00)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
        w_last = (r_count == 6'(ITER-1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and handshake outputs; flush wins over everything
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = (w_div0 | w_ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (flush)
                    w_next = S_IDLE;
                else if (w_last)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
                w_done = ~flush;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= funct3;
            r_neg   <= w_neg;
            r_b     <= w_is_div ? w_b_mag : w_a_mag;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
            r_count <= '0;
            if (w_div0 | w_ovf)
                r_result <= w_special;
        end else if (r_state == S_CALC && !flush) begin
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            r_count <= r_count + 6'd1;
            if (w_last)
                r_result <= w_final;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = w_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
// Checks latency, results, special cases, flush and async reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble inputs after accept, watch until idle
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output logic [31:0] res, output int bcyc,
                          output int npulse);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = ~f; rs1 = ~a; rs2 = ~b;
        lat = -1; res = '0; bcyc = 0; npulse = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                npulse++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (lat >= 0 && !busy) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string nm, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int exp_lat);
        int lat, bcyc, np;
        logic [31:0] res;
        run_op(f, a, b, lat, res, bcyc, np);
        checks++;
        if (lat !== exp_lat || bcyc !== exp_lat || np !== 1) begin
            failures++;
            $display("FAIL %s_timing lat=%0d busy=%0d pulses=%0d want %0d %0d 1",
                     nm, lat, bcyc, np, exp_lat, exp_lat);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s_result got=%h want=%h", nm, res, exp);
        end
    endtask

    task automatic test_mul;
        check_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        check_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 33);
        check_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000,
                 32'h40000000, 33);
        check_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 33);
        check_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    endtask

    task automatic test_div;
        check_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        check_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        check_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        check_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        check_op("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        check_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
        check_op("divu_max_1", 3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    endtask

    task automatic test_special;
        check_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        check_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        check_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 1);
        check_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    endtask

    task automatic test_flush;
        logic [31:0] prior;
        int np;
        prior = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy got=%b want=0", busy);
        end
        np = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) np++;
        end
        checks++;
        if (np !== 0 || result !== prior) begin
            failures++;
            $display("FAIL flush_nodone pulses=%0d result=%h want 0 %h",
                     np, result, prior);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b101;
        rs1 = 32'd9; rs2 = 32'd0;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prior) begin
            failures++;
            $display("FAIL flush_idle_start busy=%b done=%b result=%h want 0 0 %h",
                     busy, done, result, prior);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
